// File: rtl/clock_mode_pkg.sv
// Shared definitions for the stopwatch timebase: mode FSM encoding and 100 MHz divider defaults.
package clock_mode_pkg;

  typedef enum logic [1:0] {
    SLOW      = 2'd0,
    PEND_FAST = 2'd1,
    FAST      = 2'd2,
    PEND_SLOW = 2'd3
  } mode_state_e;

  localparam int unsigned FAST_DIV_DEFAULT   = 1000000;
  localparam int unsigned SLOW_RATIO_DEFAULT = 100;
  localparam int unsigned SCAN_DIV_DEFAULT   = 100000;

  // A pending return to slow keeps running fast until the commit edge.
  function automatic logic mode_is_fast(mode_state_e s);
    return (s == FAST) || (s == PEND_SLOW);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Enabled modulo-DIV counter; wrap is a combinational pulse on the last count while enabled.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Stopwatch timebase: fast/slow tick enables, digit-scan select and tick-aligned mode switching.
// Optional CLOCK_MODE_PENDING_EN adds a 'pending' status output.
module clock_mode_ctrl
  import clock_mode_pkg::*;
#(
  parameter int unsigned FAST_DIV   = FAST_DIV_DEFAULT,
  parameter int unsigned SLOW_RATIO = SLOW_RATIO_DEFAULT,
  parameter int unsigned SCAN_DIV   = SCAN_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_req,
  input  logic       run,
  output logic       sel_clock,
  output logic       tick_out,
  output logic       tick_fast,
  output logic       tick_slow,
`ifdef CLOCK_MODE_PENDING_EN
  output logic       pending,
`endif
  output logic [1:0] clk_ctl_out
);

  logic fast_wrap, slow_wrap, scan_wrap;
  logic tick_fast_q, tick_slow_q;
  logic [1:0] clk_ctl_q;
  mode_state_e state_q, state_d;

  tick_divider #(.DIV(FAST_DIV)) u_fast_div (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .wrap (fast_wrap)
  );

  // Slow divider only advances on fast wraps, so every slow tick coincides with a fast tick.
  tick_divider #(.DIV(SLOW_RATIO)) u_slow_div (
    .clk  (clk),
    .rst  (rst),
    .en   (fast_wrap),
    .wrap (slow_wrap)
  );

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .wrap (scan_wrap)
  );

  // A request seen together with slow_wrap cancels rather than commits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOW:      if (sel_req) state_d = PEND_FAST;
      PEND_FAST: begin
        if (sel_req) state_d = SLOW;
        else if (slow_wrap) state_d = FAST;
      end
      FAST:      if (sel_req) state_d = PEND_SLOW;
      PEND_SLOW: begin
        if (sel_req) state_d = FAST;
        else if (slow_wrap) state_d = SLOW;
      end
      default:   state_d = SLOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SLOW;
      tick_fast_q <= 1'b0;
      tick_slow_q <= 1'b0;
      clk_ctl_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      tick_fast_q <= fast_wrap;
      tick_slow_q <= slow_wrap;
      if (scan_wrap) begin
        clk_ctl_q <= clk_ctl_q + 2'd1;
      end
    end
  end

  assign sel_clock   = mode_is_fast(state_q);
  assign tick_fast   = tick_fast_q;
  assign tick_slow   = tick_slow_q;
  assign tick_out    = sel_clock ? tick_fast_q : tick_slow_q;
  assign clk_ctl_out = clk_ctl_q;

`ifdef CLOCK_MODE_PENDING_EN
  assign pending = (state_q == PEND_FAST) || (state_q == PEND_SLOW);
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with a scoreboard fed by an edge-counting reference model.
module tb_clock_mode_ctrl;

  localparam int FD = 4;
  localparam int SR = 3;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel_req = 1'b0;
  logic       run = 1'b0;
  logic       sel_clock, tick_out, tick_fast, tick_slow;
  logic [1:0] clk_ctl_out;
`ifdef CLOCK_MODE_PENDING_EN
  logic       pending;
`endif

  clock_mode_ctrl #(
    .FAST_DIV   (FD),
    .SLOW_RATIO (SR),
    .SCAN_DIV   (SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_req     (sel_req),
    .run         (run),
    .sel_clock   (sel_clock),
    .tick_out    (tick_out),
    .tick_fast   (tick_fast),
    .tick_slow   (tick_slow),
`ifdef CLOCK_MODE_PENDING_EN
    .pending     (pending),
`endif
    .clk_ctl_out (clk_ctl_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  string phase = "init";

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;
  exp_t sb[$];

  // Model: counts edges since reset instead of tracking divider state.
  int   m_edges, m_run_edges, m_cyc;
  logic m_fast, m_pend;

  function automatic logic [6:0] observed();
    logic p;
`ifdef CLOCK_MODE_PENDING_EN
    p = pending;
`else
    p = 1'b0;
`endif
    return {p, sel_clock, tick_out, tick_fast, tick_slow, clk_ctl_out};
  endfunction

  function automatic logic [6:0] model_edge(input logic r, input logic s);
    logic tf, ts, p;
    tf = 1'b0;
    ts = 1'b0;
    m_edges++;
    if (r) begin
      m_run_edges++;
      tf = (m_run_edges % FD) == 0;
      ts = (m_run_edges % (FD * SR)) == 0;
    end
    if (s) begin
      m_pend = !m_pend;
    end else if (m_pend && ts) begin
      m_fast = !m_fast;
      m_pend = 1'b0;
    end
`ifdef CLOCK_MODE_PENDING_EN
    p = m_pend;
`else
    p = 1'b0;
`endif
    return {p, m_fast, (m_fast ? tf : ts), tf, ts, 2'((m_edges / SD) % 4)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, got, want);
    end
  endtask

  task automatic step(input logic r, input logic s);
    exp_t e;
    run     = r;
    sel_req = s;
    e.cyc   = m_cyc + 1;
    e.v     = model_edge(r, s);
    sb.push_back(e);
    @(posedge clk);
    #1;
    m_cyc++;
    e = sb.pop_front();
    check($sformatf("cyc%0d", e.cyc), 32'(observed()), 32'(e.v));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    run     = 1'b0;
    sel_req = 1'b0;
    #2;
    check("reset_state", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    m_edges     = 0;
    m_run_edges = 0;
    m_cyc       = 0;
    m_fast      = 1'b0;
    m_pend      = 1'b0;
    sb.delete();
  endtask

  int n_fast, n_slow, n_out, n_hold_ticks, n_scan_moves, lat;
  logic [1:0] last_ctl;

  initial begin
    #2;
    // Free-running slow mode.
    phase = "A";
    do_reset();
    n_fast = 0; n_slow = 0; n_out = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 1'b0);
      n_fast += int'(tick_fast);
      n_slow += int'(tick_slow);
      n_out  += int'(tick_out);
      if (m_cyc == 4) check("first_fast", 32'(tick_fast), 32'd1);
    end
    check("fast_count", 32'(n_fast), 32'd10);
    check("slow_count", 32'(n_slow), 32'd3);
    check("out_count", 32'(n_out), 32'd3);

    // Request fast, then a cancelled request back to slow.
    phase = "B";
    do_reset();
    n_out = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, (c == 5) || (c == 14) || (c == 17));
      if (m_cyc >= 12) n_out += int'(tick_out);
      if (m_cyc == 11) check("no_early_commit", 32'(sel_clock), 32'd0);
      if (m_cyc == 12) check("commit_tick", 32'({sel_clock, tick_out}), 32'b11);
      if (m_cyc >= 12) check("stay_fast", 32'(sel_clock), 32'd1);
    end
    check("out_count", 32'(n_out), 32'd8);

    // Hold mid-period; scan keeps moving.
    phase = "C";
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_hold_ticks = 0; n_scan_moves = 0;
    last_ctl = clk_ctl_out;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0);
      n_hold_ticks += int'(tick_fast) + int'(tick_slow);
      if (clk_ctl_out != last_ctl) n_scan_moves++;
      last_ctl = clk_ctl_out;
    end
    check("hold_ticks", 32'(n_hold_ticks), 32'd0);
    check("hold_scan", 32'(n_scan_moves), 32'd5);
    lat = 0;
    do begin
      step(1'b1, 1'b0);
      lat++;
    end while (!tick_fast && lat < 10);
    check("resume_latency", 32'(lat), 32'd2);

    // Asynchronous reset while a fast request is pending.
    phase = "D";
    do_reset();
    for (int c = 0; c < 6; c++) step(1'b1, c == 2);
    #3;
    rst = 1'b1;
    #1;
    check("async_clear", 32'(observed()), 32'd0);
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b0);
      if (m_cyc == 12) check("no_commit", 32'({sel_clock, tick_slow}), 32'b01);
    end

    // Cancel arriving on the slow-wrap edge wins.
    phase = "E";
    do_reset();
    for (int c = 0; c < 24; c++) begin
      step(1'b1, (c == 3) || (c == 11));
      if (m_cyc == 12) check("cancel_wins", 32'({sel_clock, tick_slow}), 32'b01);
    end
    check("final_slow", 32'(sel_clock), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
